// File: rtl/regfile32.sv
// regfile32 - integer register file, two combinational read ports and one
// synchronous write port. Register 0 always reads as zero.
//
// Ports:
//   clk      - system clock, all state updates on the rising edge
//   rst_n    - synchronous active-low reset (clears contents and wr_cnt)
//   ra_addr  - read port A address
//   rb_addr  - read port B address
//   we       - write enable
//   w_addr   - write address
//   w_data   - write data
//   a        - read data, port A (operand a)
//   b        - read data, port B (operand b)
//   wr_cnt   - committed writes since reset, saturating at 16'hFFFF
module regfile32 #(
  parameter int WIDTH  = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_addr,
  input  logic [AW-1:0]    rb_addr,
  input  logic             we,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [15:0]      wr_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0] wen;
  logic [15:0]      wr_cnt_reg;
  logic             wr_commit;

  // A write to address 0 is accepted on the bus but has no effect at all.
  assign wr_commit = we && (w_addr != '0);

  // One-hot write decode; entry 0 never gets an enable, so it stays zero.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wen
      if (gi == 0) begin : g_zero
        assign wen[gi] = 1'b0;
      end else begin : g_entry
        assign wen[gi] = wr_commit && (w_addr == AW'(gi));
      end
    end
  endgenerate

  // Reset wins over a write presented on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wen[i]) begin
          mem_reg[i] <= w_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt_reg <= '0;
    end else if (wr_commit && (wr_cnt_reg != 16'hFFFF)) begin
      wr_cnt_reg <= wr_cnt_reg + 16'd1;
    end
  end

  assign wr_cnt = wr_cnt_reg;

  // Read ports: zero during reset and for address 0; with BYPASS the data
  // being written this cycle is forwarded to a matching read address.
  always_comb begin
    a = mem_reg[ra_addr];
    if (!rst_n || (ra_addr == '0)) begin
      a = '0;
    end else if ((BYPASS != 0) && we && (w_addr == ra_addr)) begin
      a = w_data;
    end
  end

  always_comb begin
    b = mem_reg[rb_addr];
    if (!rst_n || (rb_addr == '0)) begin
      b = '0;
    end else if ((BYPASS != 0) && we && (w_addr == rb_addr)) begin
      b = w_data;
    end
  end

endmodule

// File: tb/tb_regfile32.sv
// tb_regfile32 - bench for regfile32. Two instances share all inputs: one
// with write-to-read bypass, one without. A directed vector table covers
// the reset, register-0, bypass and collision cases; a sweep, a random run
// against a behavioural model, and a counter-saturation run follow.
module tb_regfile32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra_addr, rb_addr, w_addr;
  logic        we;
  logic [31:0] w_data;
  logic [31:0] a_byp, b_byp, a_nb, b_nb;
  logic [15:0] cnt_byp, cnt_nb;

  int checks = 0;
  int errors = 0;

  // Behavioural model: plain array plus an integer counter.
  logic [31:0] model_mem [32];
  int          model_cnt;

  always #5 clk = ~clk;

  regfile32 #(.WIDTH(32), .AW(5), .BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .a(a_byp), .b(b_byp), .wr_cnt(cnt_byp)
  );

  regfile32 #(.WIDTH(32), .AW(5), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .ra_addr(ra_addr), .rb_addr(rb_addr),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .a(a_nb), .b(b_nb), .wr_cnt(cnt_nb)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] ea_nb;
    logic [31:0] eb_nb;
    logic [15:0] ecnt;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                              logic [4:0] ra, logic [4:0] rb,
                              logic [31:0] ea, logic [31:0] eb,
                              logic [31:0] ea_nb, logic [31:0] eb_nb,
                              logic [15:0] ecnt);
    vec_t v;
    v.rst_n = r; v.we = w; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
    v.ea = ea; v.eb = eb; v.ea_nb = ea_nb; v.eb_nb = eb_nb; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic r, logic w, logic [4:0] wa, logic [31:0] wd,
                       logic [4:0] ra, logic [4:0] rb);
    rst_n = r; we = w; w_addr = wa; w_data = wd; ra_addr = ra; rb_addr = rb;
    #2;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
      model_cnt = 0;
    end else if (we && (w_addr != 5'd0)) begin
      model_mem[w_addr] = w_data;
      if (model_cnt < 65535) model_cnt++;
    end
    #1;
  endtask

  function automatic logic [31:0] model_read(logic [4:0] addr, bit byp);
    if (!rst_n || (addr == 5'd0)) return 32'h0;
    if (byp && we && (w_addr == addr)) return w_data;
    return model_mem[addr];
  endfunction

  task automatic chk_model(string tag);
    chk({tag, "_a_byp"}, a_byp, model_read(ra_addr, 1'b1));
    chk({tag, "_b_byp"}, b_byp, model_read(rb_addr, 1'b1));
    chk({tag, "_a_nb"},  a_nb,  model_read(ra_addr, 1'b0));
    chk({tag, "_b_nb"},  b_nb,  model_read(rb_addr, 1'b0));
    chk({tag, "_cnt_byp"}, {16'h0, cnt_byp}, model_cnt);
    chk({tag, "_cnt_nb"},  {16'h0, cnt_nb},  model_cnt);
  endtask

  initial begin
    // Initial reset; the outputs are forced to zero while rst_n is low.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd17);
    chk("rst_a", a_byp, 32'h0);
    chk("rst_b", b_byp, 32'h0);
    tick();
    chk("rst_cnt", {16'h0, cnt_byp}, 32'h0);
    $display("reset: cnt=%0d", cnt_byp);

    // Directed vectors; expectations are the values seen before each edge.
    tbl[0]  = mk(1, 1, 5, 32'hDEADBEEF, 5, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 32'h0,        5, 5, 0, 0, 0, 0, 1);
    tbl[2]  = mk(1, 0, 0, 32'h0,        5, 5, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 32'h0000FFFF, 1, 2, 32'h0000FFFF, 0, 0, 0, 0);
    tbl[4]  = mk(1, 1, 2, 32'h00FF00FF, 1, 2, 32'h0000FFFF, 32'h00FF00FF, 32'h0000FFFF, 0, 1);
    tbl[5]  = mk(1, 0, 0, 32'h0,        1, 2, 32'h0000FFFF, 32'h00FF00FF, 32'h0000FFFF, 32'h00FF00FF, 2);
    tbl[6]  = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 2);
    tbl[7]  = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 2);
    tbl[8]  = mk(1, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 2);
    tbl[9]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 2);
    tbl[10] = mk(1, 1, 7, 32'h00000001, 0, 0, 0, 0, 0, 0, 2);
    tbl[11] = mk(1, 1, 7, 32'hFFFFFFFC, 7, 7, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1, 3);
    tbl[12] = mk(1, 0, 0, 32'h0,        7, 7, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFFFFC, 4);
    tbl[13] = mk(1, 1, 3, 32'hA5A5A5A5, 3, 1, 32'hA5A5A5A5, 32'h0000FFFF, 0, 32'h0000FFFF, 4);
    tbl[14] = mk(0, 1, 3, 32'h12345678, 3, 3, 0, 0, 0, 0, 5);
    tbl[15] = mk(1, 0, 0, 32'h0,        3, 7, 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst_n, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, tbl[i].rb);
      chk($sformatf("vec%0d_a_byp", i), a_byp, tbl[i].ea);
      chk($sformatf("vec%0d_b_byp", i), b_byp, tbl[i].eb);
      chk($sformatf("vec%0d_a_nb", i),  a_nb,  tbl[i].ea_nb);
      chk($sformatf("vec%0d_b_nb", i),  b_nb,  tbl[i].eb_nb);
      chk($sformatf("vec%0d_cnt", i), {16'h0, cnt_byp}, {16'h0, tbl[i].ecnt});
      chk($sformatf("vec%0d_cnt_nb", i), {16'h0, cnt_nb}, {16'h0, tbl[i].ecnt});
      if (i == 5) chk("and32_y", a_byp & b_byp, 32'h000000FF);
      $display("vec %0d: rst_n=%0b we=%0b wa=%0d wd=%h ra=%0d rb=%0d a=%h b=%h a_nb=%h b_nb=%h cnt=%0d",
               i, rst_n, we, w_addr, w_data, ra_addr, rb_addr, a_byp, b_byp, a_nb, b_nb, cnt_byp);
      tick();
    end

    // Sweep: r1..r31 = i-4, then read every address pair.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'(i) - 32'd4, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 32; j++) begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 5'(i), 5'(j));
        chk($sformatf("sweep_a_%0d", i), a_byp, (i == 0) ? 32'h0 : 32'(i) - 32'd4);
        chk($sformatf("sweep_b_%0d", j), b_nb,  (j == 0) ? 32'h0 : 32'(j) - 32'd4);
        tick();
      end
    end
    chk("sweep_cnt", {16'h0, cnt_byp}, 32'd31);
    $display("sweep: 31 writes, 1024 read pairs, cnt=%0d", cnt_byp);

    // Random traffic with occasional resets, checked against the model.
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(0, 49) != 0), 1'($urandom()),
            5'($urandom()), $urandom(),
            (($urandom_range(0, 3) == 0) ? w_addr : 5'($urandom())),
            5'($urandom()));
      chk_model("rand");
      tick();
    end
    $display("random: 2000 cycles, cnt=%0d", cnt_byp);

    // Counter saturation: 65540 committed writes.
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    for (int n = 1; n <= 65540; n++) begin
      drive(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom(), 5'd0, 5'd0);
      tick();
      if (n == 65534) chk("sat_cnt_65534", {16'h0, cnt_byp}, 32'h0000FFFE);
      if (n == 65535) chk("sat_cnt_65535", {16'h0, cnt_byp}, 32'h0000FFFF);
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'($urandom_range(1, 31)), 5'($urandom_range(1, 31)));
    chk("sat_cnt_byp", {16'h0, cnt_byp}, 32'h0000FFFF);
    chk("sat_cnt_nb",  {16'h0, cnt_nb},  32'h0000FFFF);
    chk_model("sat");
    $display("saturation: 65540 writes, cnt=%h", cnt_byp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile32.md
Name: regfile32

Overview:
- Integer register file: 2 read ports, 1 write port.
- Supplies the two 32-bit operands a/b to the datapath's logic units (and32 and siblings) and accepts the ALU result back on the write port.
- Register 0 is hardwired to zero.
- Writes are synchronous; reads are combinational, with optional same-cycle write-to-read bypass.

Parameters:
- WIDTH, 32, data width of every register and port.
- AW, 5, address width; depth = 2**AW registers.
- BYPASS, 1, 1 = a read of the register being written this cycle returns w_data; 0 = returns the old stored value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
- ra_addr  input  AW  read port A address.
- rb_addr  input  AW  read port B address.
- we  input  1  write enable.
- w_addr  input  AW  write address.
- w_data  input  WIDTH  write data.
- a  output  WIDTH  read data, port A (operand a).
- b  output  WIDTH  read data, port B (operand b).
- wr_cnt  output  16  count of committed writes since reset; saturates at 16'hFFFF.

Behaviour:
- Storage: 2**AW entries of WIDTH bits. Entry 0 is not stored, or is never updated.
- Reset:
  - On a rising clk edge with rst_n==0, every entry is cleared to 0 and wr_cnt is cleared to 0.
  - While rst_n==0, a and b are forced to 0 combinationally.
  - Reset has priority over a simultaneous write: a we=1 on the reset edge is discarded and not counted.
- Write:
  - On a rising edge with rst_n==1, we==1 and w_addr!=0: entry[w_addr] <= w_data, and wr_cnt increments by 1, stopping at 16'hFFFF (no wrap).
  - we==1 with w_addr==0 is accepted but ignored: no store and no wr_cnt increment.
  - we==0: no state change.
- Read, combinational, same-cycle:
  - ra_addr==0 -> a = 0 always, including when a write to address 0 is in progress.
  - If BYPASS==1, rst_n==1, we==1, w_addr==ra_addr and ra_addr!=0 -> a = w_data.
  - Otherwise a = entry[ra_addr].
  - Port B follows identical rules using rb_addr.
  - Both ports may address the same register; both return the same value.
- Latency:
  - Write-to-read is 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Read address to data is combinational (0 cycles).
- Back-to-back writes to the same address: the last write wins. Each write counts separately in wr_cnt.
- Reset mid-operation: asserting rst_n for a single edge between writes clears all contents. The next read returns 0 until the register is rewritten.
- No X propagation: every output is defined for all input combinations once the first reset edge has occurred.
- Out-of-range addresses cannot occur: the address width exactly covers the depth.

Test Plan:
- Reset clear:
  - Write 32'hDEADBEEF to r5, hold rst_n=0 for one edge, release, read ra=5 -> a=0, wr_cnt=0.
  - During reset, a=b=0 regardless of addresses.
- Basic write/read, both ports:
  - Write r1=32'h0000FFFF and r2=32'h00FF00FF.
  - Set ra=1, rb=2 -> a=32'h0000FFFF, b=32'h00FF00FF, wr_cnt=2.
  - Feeding these into and32 gives y=32'h000000FF.
- Register 0 immutable:
  - we=1, w_addr=0, w_data=32'hFFFFFFFF for 3 edges.
  - ra=rb=0 -> a=b=0 during and after the writes; wr_cnt unchanged.
- Bypass:
  - With BYPASS=1: r7 holds 32'h1. In the same cycle as we=1, w_addr=7, w_data=32'hFFFFFFFC with ra=7, rb=7 -> a=b=32'hFFFFFFFC before the edge.
  - With BYPASS=0, same stimulus -> a=b=32'h1 before the edge and 32'hFFFFFFFC after it.
- Reset vs write collision:
  - r3 holds 32'hA5A5A5A5. Apply rst_n=0 with we=1, w_addr=3, w_data=32'h12345678 on the same edge.
  - After release, a (ra=3)=0 and wr_cnt=0.
- Counter saturation and sweep:
  - Write each of r1..r31 with value -4+i (two's complement, e.g. r1=32'hFFFFFFFD), then read every pair -> stored values returned.
  - Force 65,540 writes -> wr_cnt holds at 16'hFFFF.
